// File: rtl/adc_frontend_pkg.sv
// Shared types and helpers for the ADC front end and its DC estimator.
package adc_frontend_pkg;

   typedef enum logic [1:0] {
      WARMUP = 2'd0,
      TRACK  = 2'd1,
      FROZEN = 2'd2
   } dc_state_e;

   // Largest value representable in a w-bit two's complement word.
   function automatic int sat_max(input int w);
      return (1 << (w - 1)) - 1;
   endfunction

   // Smallest value representable in a w-bit two's complement word.
   function automatic int sat_min(input int w);
      return -(1 << (w - 1));
   endfunction

   // Offset-binary to two's complement for a w-bit word: flip the MSB.
   function automatic logic [31:0] ob_to_tc(input logic [31:0] x, input int w);
      return x ^ (32'd1 << (w - 1));
   endfunction

endpackage

// File: rtl/adc_frontend_if.sv
// Sample stream into the front end and conditioned stream out of it.
interface adc_frontend_if #(
   parameter int ADC_W = 12,
   parameter int OW    = 12
) ();
   logic [ADC_W-1:0]     adc_data;
   logic                 adc_ovr;
   logic                 adc_valid;
   logic signed [OW-1:0] out_data;
   logic                 out_valid;

   // Source side: drives raw samples, consumes conditioned ones.
   modport master (output adc_data, adc_ovr, adc_valid, input out_data, out_valid);
   // Front-end side.
   modport slave  (input adc_data, adc_ovr, adc_valid, output out_data, out_valid);
endinterface

// File: rtl/adc_frontend_dc_est.sv
// Block-average DC estimator: sums 2^AVG_LOG2 valid samples, publishes the
// floored mean, and gates accumulation while frozen.
module dc_offset_estimator
   import adc_frontend_pkg::*;
#(
   parameter int ADC_W    = 12,
   parameter int AVG_LOG2 = 12
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    smp_vld,
   input  logic signed [ADC_W-1:0] smp,
   input  logic                    freeze,
   output logic signed [ADC_W-1:0] offset,
   output logic                    dc_valid
);
   localparam int ACC_W = ADC_W + AVG_LOG2;

   dc_state_e               state_q, state_d;
   logic signed [ACC_W-1:0] acc_q, acc_d, acc_sum;
   logic [AVG_LOG2-1:0]     cnt_q, cnt_d;
   logic signed [ADC_W-1:0] off_q, off_d;
   logic                    acc_en, win_done;

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= WARMUP;
         acc_q   <= '0;
         cnt_q   <= '0;
         off_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         off_q   <= off_d;
      end
   end

   // Accumulate unless frozen; the last sample of a window closes it out.
   always_comb begin
      acc_en   = smp_vld && !freeze;
      win_done = acc_en && (cnt_q == '1);
      acc_sum  = acc_q + ACC_W'(smp);
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      off_d    = off_q;
      if (win_done) begin
         acc_d = '0;
         cnt_d = '0;
         off_d = ADC_W'(acc_sum >>> AVG_LOG2);
      end else if (acc_en) begin
         acc_d = acc_sum;
         cnt_d = cnt_q + AVG_LOG2'(1);
      end
   end

   // Next state: first window leaves warm-up, freeze toggles TRACK/FROZEN.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         WARMUP:  if (win_done) state_d = TRACK;
         TRACK:   if (freeze)   state_d = FROZEN;
         FROZEN:  if (!freeze)  state_d = TRACK;
         default: state_d = WARMUP;
      endcase
   end

   // Outputs: estimate is trusted once any window has completed.
   always_comb begin
      dc_valid = (state_q != WARMUP);
      offset   = off_q;
   end

endmodule

// File: rtl/adc_frontend.sv
// ADC input conditioning: offset-binary to two's complement, DC removal with
// saturation to OW bits, and overrange tracking. Two register stages.
module adc_frontend
   import adc_frontend_pkg::*;
#(
   parameter int ADC_W    = 12,
   parameter int OW       = 12,
   parameter int AVG_LOG2 = 12,
   parameter int CNT_W    = 16
) (
   input  logic              sys_clk,
   input  logic              rst,
   adc_frontend_if.slave     bus,
   input  logic              dc_remove_en,
   input  logic              offset_freeze,
   input  logic              ovr_clear,
   output logic              dc_valid,
   output logic [ADC_W-1:0]  dbg_dc_offset,
   output logic              ovr_flag,
   output logic [CNT_W-1:0]  ovr_count
);
   localparam logic signed [OW:0] SAT_HI = (OW + 1)'(sat_max(OW));
   localparam logic signed [OW:0] SAT_LO = (OW + 1)'(sat_min(OW));

   logic signed [ADC_W-1:0] raw_s_q, raw_s_d;
   logic [1:0]              vld_pipe_q, vld_pipe_d;  // [0] stage 0, [1] output
   logic                    ovr_evt_q, ovr_evt_d;
   logic signed [OW-1:0]    out_data_q, out_data_d;
   logic                    ovr_flag_q, ovr_flag_d;
   logic [CNT_W-1:0]        ovr_cnt_q, ovr_cnt_d;

   logic signed [ADC_W-1:0] dc_off, sub;
   logic signed [ADC_W:0]   diff;
   logic signed [OW:0]      diff_ext;

   dc_offset_estimator #(.ADC_W(ADC_W), .AVG_LOG2(AVG_LOG2)) u_est (
      .clk      (sys_clk),
      .rst      (rst),
      .smp_vld  (vld_pipe_q[0]),
      .smp      (raw_s_q),
      .freeze   (offset_freeze),
      .offset   (dc_off),
      .dc_valid (dc_valid)
   );

   // Pipeline and overrange registers.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         raw_s_q    <= '0;
         vld_pipe_q <= '0;
         ovr_evt_q  <= 1'b0;
         out_data_q <= '0;
         ovr_flag_q <= 1'b0;
         ovr_cnt_q  <= '0;
      end else begin
         raw_s_q    <= raw_s_d;
         vld_pipe_q <= vld_pipe_d;
         ovr_evt_q  <= ovr_evt_d;
         out_data_q <= out_data_d;
         ovr_flag_q <= ovr_flag_d;
         ovr_cnt_q  <= ovr_cnt_d;
      end
   end

   // Stage 0: format conversion; rail codes count as overrange too.
   always_comb begin
      raw_s_d    = ADC_W'(ob_to_tc(32'(bus.adc_data), ADC_W));
      vld_pipe_d = {vld_pipe_q[0], bus.adc_valid};
      ovr_evt_d  = bus.adc_valid && (bus.adc_ovr || (&bus.adc_data) || !(|bus.adc_data));
   end

   // Stage 1: subtract estimate with one guard bit, clamp, hold when idle.
   always_comb begin
      sub      = dc_remove_en ? dc_off : '0;
      diff     = $signed({raw_s_q[ADC_W-1], raw_s_q}) - $signed({sub[ADC_W-1], sub});
      diff_ext = (OW + 1)'(diff);
      out_data_d = out_data_q;
      if (vld_pipe_q[0]) begin
         if (diff_ext > SAT_HI)      out_data_d = SAT_HI[OW-1:0];
         else if (diff_ext < SAT_LO) out_data_d = SAT_LO[OW-1:0];
         else                        out_data_d = diff_ext[OW-1:0];
      end
   end

   // Overrange: a coincident event beats clear, so nothing is lost.
   always_comb begin
      ovr_flag_d = ovr_flag_q;
      ovr_cnt_d  = ovr_cnt_q;
      if (ovr_evt_q) begin
         ovr_flag_d = 1'b1;
         if (ovr_clear)       ovr_cnt_d = CNT_W'(1);
         else if (~&ovr_cnt_q) ovr_cnt_d = ovr_cnt_q + CNT_W'(1);
      end else if (ovr_clear) begin
         ovr_flag_d = 1'b0;
         ovr_cnt_d  = '0;
      end
   end

   assign bus.out_data   = out_data_q;
   assign bus.out_valid  = vld_pipe_q[1];
   assign dbg_dc_offset  = dc_off;
   assign ovr_flag       = ovr_flag_q;
   assign ovr_count      = ovr_cnt_q;

endmodule

// File: tb/tb_adc_frontend.sv
// Directed bench for adc_frontend with a sample-level reference model.
module tb_adc_frontend;
   localparam int ADC_W = 12, OW = 12, AVG_LOG2 = 4, CNT_W = 4;
   localparam int N    = 1 << AVG_LOG2;
   localparam int HI   = (1 << (OW - 1)) - 1;
   localparam int LO   = -(1 << (OW - 1));
   localparam int CMAX = (1 << CNT_W) - 1;
   localparam int MID  = 1 << (ADC_W - 1);

   logic sys_clk = 1'b0, rst = 1'b1;
   logic dc_remove_en = 1'b1, offset_freeze = 1'b0, ovr_clear = 1'b0;
   logic dc_valid, ovr_flag;
   logic [ADC_W-1:0] dbg_dc_offset;
   logic [CNT_W-1:0] ovr_count;

   adc_frontend_if #(.ADC_W(ADC_W), .OW(OW)) bus ();

   adc_frontend #(.ADC_W(ADC_W), .OW(OW), .AVG_LOG2(AVG_LOG2), .CNT_W(CNT_W)) dut (
      .sys_clk       (sys_clk),
      .rst           (rst),
      .bus           (bus),
      .dc_remove_en  (dc_remove_en),
      .offset_freeze (offset_freeze),
      .ovr_clear     (ovr_clear),
      .dc_valid      (dc_valid),
      .dbg_dc_offset (dbg_dc_offset),
      .ovr_flag      (ovr_flag),
      .ovr_count     (ovr_count)
   );

   always #5 sys_clk = ~sys_clk;

   int n_tests = 0, n_fail = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int floor_div(input int a, input int b);
      int q;
      q = a / b;
      if ((a % b != 0) && (a < 0)) q = q - 1;
      return q;
   endfunction

   // Reference model: a sample is seen by the estimator one edge after it is
   // presented and reaches the output on the following edge, using whatever
   // estimate was published before that edge.
   int p_v, p_x, p_evt;
   int e_out, e_ov, m_sum, m_n, m_off, m_dcv, m_flag, m_cnt, md;
   always @(posedge sys_clk) begin
      if (rst) begin
         p_v = 0; p_x = 0; p_evt = 0; e_out = 0; e_ov = 0;
         m_sum = 0; m_n = 0; m_off = 0; m_dcv = 0; m_flag = 0; m_cnt = 0;
      end else begin
         if (p_v != 0) begin
            md    = p_x - (dc_remove_en ? m_off : 0);
            e_out = (md > HI) ? HI : ((md < LO) ? LO : md);
         end
         e_ov = p_v;
         if ((p_v != 0) && !offset_freeze) begin
            m_sum += p_x;
            m_n++;
            if (m_n == N) begin
               m_off = floor_div(m_sum, N);
               m_sum = 0; m_n = 0; m_dcv = 1;
            end
         end
         if (p_evt != 0) begin
            m_flag = 1;
            m_cnt  = ovr_clear ? 1 : ((m_cnt < CMAX) ? m_cnt + 1 : CMAX);
         end else if (ovr_clear) begin
            m_flag = 0; m_cnt = 0;
         end
         p_v   = int'(bus.adc_valid);
         p_x   = int'(bus.adc_data) - MID;
         p_evt = int'(bus.adc_valid && (bus.adc_ovr || bus.adc_data == '0 || bus.adc_data == '1));
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge sys_clk) begin
      if (chk_en) begin
         chk("m_out_valid", int'(bus.out_valid), e_ov);
         chk("m_out_data", int'($signed(bus.out_data)), e_out);
         chk("m_dc_valid", int'(dc_valid), m_dcv);
         chk("m_dc_offset", int'($signed(dbg_dc_offset)), m_off);
         chk("m_ovr_flag", int'(ovr_flag), m_flag);
         chk("m_ovr_count", int'(ovr_count), m_cnt);
      end
   end

   task automatic put(input logic [ADC_W-1:0] d, input logic ovr, input logic v);
      @(negedge sys_clk);
      bus.adc_data = d; bus.adc_ovr = ovr; bus.adc_valid = v;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) put(12'h800, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge sys_clk);
      rst = 1'b1; bus.adc_valid = 1'b0; bus.adc_ovr = 1'b0;
      @(negedge sys_clk);
      rst = 1'b0;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_out_data"}, int'($signed(bus.out_data)), 0);
      chk({tag, "_out_valid"}, int'(bus.out_valid), 0);
      chk({tag, "_dc_valid"}, int'(dc_valid), 0);
      chk({tag, "_offset"}, int'($signed(dbg_dc_offset)), 0);
      chk({tag, "_flag"}, int'(ovr_flag), 0);
      chk({tag, "_count"}, int'(ovr_count), 0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.adc_data = 12'h800; bus.adc_ovr = 1'b0; bus.adc_valid = 1'b0;
      do_reset();
      chk_en = 1'b1;
      chk_zero("reset");

      // 1: constant +16 DC, continuous strobe
      put(12'h810, 1'b0, 1'b1);
      put(12'h810, 1'b0, 1'b1);
      chk("lat_cycle1_valid", int'(bus.out_valid), 0);
      put(12'h810, 1'b0, 1'b1);
      chk("lat_cycle2_valid", int'(bus.out_valid), 1);
      chk("lat_cycle2_data", int'($signed(bus.out_data)), 16);
      for (int i = 0; i < 14; i++) put(12'h810, 1'b0, 1'b1);
      chk("dcv_before_16", int'(dc_valid), 0);
      put(12'h810, 1'b0, 1'b1);
      chk("dcv_after_16", int'(dc_valid), 1);
      chk("offset_16", int'($signed(dbg_dc_offset)), 16);
      chk("sample16_uncorr", int'($signed(bus.out_data)), 16);
      put(12'h810, 1'b0, 1'b1);
      chk("first_corrected", int'($signed(bus.out_data)), 0);
      for (int i = 0; i < 21; i++) put(12'h810, 1'b0, 1'b1);
      idle(2);

      // 2: saturation and overrange on the low rail
      for (int i = 0; i < 3; i++) put(12'h000, 1'b0, 1'b1);
      idle(2);
      chk("sat_low_clamp", int'($signed(bus.out_data)), -2048);
      chk("sat_flag", int'(ovr_flag), 1);
      chk("sat_count3", int'(ovr_count), 3);
      dc_remove_en = 1'b0;
      put(12'h000, 1'b0, 1'b1);
      idle(2);
      chk("nodc_low", int'($signed(bus.out_data)), -2048);
      chk("nodc_count4", int'(ovr_count), 4);
      put(12'h810, 1'b0, 1'b1);
      idle(2);
      chk("nodc_raw16", int'($signed(bus.out_data)), 16);
      dc_remove_en = 1'b1;

      // 3: gapped strobe, negative DC, then a mean of -0.5 that floors to -1
      do_reset();
      for (int i = 0; i < 64; i++) put(12'h7F0, 1'b0, (i % 4) == 0);
      chk("gap_dcv", int'(dc_valid), 1);
      chk("gap_offset_m16", int'($signed(dbg_dc_offset)), -16);
      for (int i = 0; i < 64; i++)
         put(((i / 4) % 2) ? 12'h800 : 12'h7FF, 1'b0, (i % 4) == 0);
      chk("floor_offset_m1", int'($signed(dbg_dc_offset)), -1);
      chk("floor_last_out", int'($signed(bus.out_data)), 16);

      // 4: freeze in warm-up, then in track
      do_reset();
      offset_freeze = 1'b1;
      for (int i = 0; i < 20; i++) put(12'h810, 1'b0, 1'b1);
      idle(2);
      chk("warm_freeze_dcv", int'(dc_valid), 0);
      chk("warm_freeze_off", int'($signed(dbg_dc_offset)), 0);
      offset_freeze = 1'b0;
      for (int i = 0; i < 16; i++) put(12'h810, 1'b0, 1'b1);
      idle(2);
      chk("trk_offset16", int'($signed(dbg_dc_offset)), 16);
      offset_freeze = 1'b1;
      for (int i = 0; i < 40; i++) put(12'h820, 1'b0, 1'b1);
      idle(2);
      chk("frz_offset", int'($signed(dbg_dc_offset)), 16);
      chk("frz_out", int'($signed(bus.out_data)), 16);
      chk("frz_dcv", int'(dc_valid), 1);
      offset_freeze = 1'b0;
      for (int i = 0; i < 16; i++) put(12'h820, 1'b0, 1'b1);
      idle(2);
      chk("rel_offset32", int'($signed(dbg_dc_offset)), 32);
      put(12'h820, 1'b0, 1'b1);
      idle(2);
      chk("rel_out0", int'($signed(bus.out_data)), 0);

      // 5: overrange count, clear, clear/event collision, saturation
      do_reset();
      for (int i = 0; i < 3; i++) begin
         put(12'h900, 1'b1, 1'b1);
         put(12'h900, 1'b0, 1'b1);
      end
      idle(2);
      chk("ovr_count3", int'(ovr_count), 3);
      ovr_clear = 1'b1;
      idle(1);
      ovr_clear = 1'b0;
      chk("clr_flag", int'(ovr_flag), 0);
      chk("clr_count", int'(ovr_count), 0);
      put(12'h900, 1'b1, 1'b1);
      put(12'h900, 1'b1, 1'b1);
      idle(2);
      put(12'h900, 1'b1, 1'b1);
      idle(1);
      ovr_clear = 1'b1;
      idle(1);
      ovr_clear = 1'b0;
      chk("coll_flag", int'(ovr_flag), 1);
      chk("coll_count1", int'(ovr_count), 1);
      for (int i = 0; i < 20; i++) put((i % 2) ? 12'hFFF : 12'h000, 1'b0, 1'b1);
      idle(2);
      chk("cnt_sat15", int'(ovr_count), 15);

      // 6: reset mid-window discards the partial sum
      do_reset();
      put(12'h810, 1'b1, 1'b1);
      for (int i = 0; i < 9; i++) put(12'h810, 1'b0, 1'b1);
      do_reset();
      chk_zero("midrst");
      for (int i = 0; i < 15; i++) put(12'h830, 1'b0, 1'b1);
      idle(2);
      chk("post_rst_dcv15", int'(dc_valid), 0);
      put(12'h830, 1'b0, 1'b1);
      idle(2);
      chk("post_rst_dcv16", int'(dc_valid), 1);
      chk("post_rst_off48", int'($signed(dbg_dc_offset)), 48);

      idle(3);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/adc_frontend.md
Name: adc_frontend

Overview:
- Input conditioning stage directly upstream of the downconversion CORDIC.
- Accepts offset-binary ADC words and converts them to two's complement.
- Removes DC offset using a block-average estimator and saturates the result to the CORDIC input width.
- Tracks ADC overrange events; the block's out_data/out_valid drive the downconverter's i_yval and sample enable.

Parameters:
ADC_W, 12, ADC sample width (offset-binary)
OW, 12, output width (signed); must be >= ADC_W
AVG_LOG2, 12, log2 of DC-estimation window length in valid samples (range 2..16)
CNT_W, 16, width of the saturating overrange counter

Ports:
sys_clk  in  1  system clock; all logic is on the rising edge
rst  in  1  synchronous, active-high reset
adc_data  in  ADC_W  raw ADC sample, offset-binary
adc_ovr  in  1  ADC overrange pin, qualified by adc_valid
adc_valid  in  1  sample strobe; may be high every cycle or gapped
dc_remove_en  in  1  1 = subtract the estimate; 0 = subtract zero
offset_freeze  in  1  hold the estimator (accumulator, counter and estimate)
ovr_clear  in  1  single-cycle clear of ovr_flag and ovr_count
out_data  out  OW  signed, offset-corrected, saturated sample
out_valid  out  1  qualifies out_data
dc_valid  out  1  high once the first window has completed
dbg_dc_offset  out  ADC_W  current signed offset estimate
ovr_flag  out  1  sticky overrange indicator
ovr_count  out  CNT_W  saturating overrange event count

Behaviour:
- Reset (already decided): one clock, sys_clk; rst is synchronous and active-high. With rst high, every register clears on the next edge: out_data=0, out_valid=0, dc_valid=0, dbg_dc_offset=0, ovr_flag=0, ovr_count=0, accumulator=0, window counter=0, FSM=WARMUP. Reset mid-window discards the partial sum.
- Stage 0, registered:
  - raw_s = {~adc_data[ADC_W-1], adc_data[ADC_W-2:0]}
  - the valid bit is pipelined alongside.
- Stage 1, registered:
  - diff = raw_s - (dc_remove_en ? offset : 0), computed in ADC_W+1 bits.
  - Sign-extend diff to OW+1 bits, then clamp to [-2^(OW-1), 2^(OW-1)-1].
  - Result goes to out_data with out_valid.
- Latency: a sample with adc_valid at edge n appears on out_data/out_valid at edge n+2. Gaps in adc_valid propagate unchanged. out_data holds its value when out_valid=0.
- Estimator:
  - Signed accumulator, ADC_W+AVG_LOG2 bits; window counter, AVG_LOG2 bits. Both advance only on stage-0 valid samples, using raw_s (uncorrected).
  - On the sample where the counter equals 2^AVG_LOG2-1:
    - offset <= (acc + raw_s) >>> AVG_LOG2 (arithmetic shift, floor)
    - acc <= 0, counter <= 0
  - The new offset takes effect on the next sample entering stage 1.
- FSM states:
  - WARMUP: offset=0, dc_valid=0. First window completes -> TRACK.
  - TRACK: dc_valid=1; the estimate updates every window. offset_freeze=1 -> FROZEN.
  - FROZEN: acc, counter and offset held; incoming samples are not accumulated. offset_freeze=0 -> TRACK, resuming the partial window.
  - offset_freeze asserted in WARMUP holds acc and counter, stays in WARMUP, and dc_valid remains 0.
- Overrange:
  - An event is a stage-0 valid sample with (adc_ovr=1) OR (adc_data all-zeros) OR (adc_data all-ones). adc_ovr is registered with the data.
  - On an event: ovr_flag <= 1; ovr_count increments and saturates at 2^CNT_W-1.
  - ovr_clear alone sets flag=0 and count=0.
  - ovr_clear together with an event: the event wins, so flag=1 and count=1.

Decomposition:
- Shared package adc_frontend_pkg holds:
  - the FSM state encoding typedef (WARMUP, TRACK, FROZEN)
  - a saturation-limit function sat_max/sat_min(OW)
  - the offset-binary conversion function
- One natural sub-module, dc_offset_estimator: accumulator, counter, FSM and the dc_valid/offset outputs. The top level holds the format conversion, the subtract/saturate pipeline and the overrange logic.

Test Plan:
1. Estimate and remove DC (AVG_LOG2=4, adc_valid=1 every cycle): adc_data=12'h810 constant -> out_data=+16 for the first 16 outputs. dc_valid rises after the 16th sample. dbg_dc_offset=16. Later outputs are 0. Latency of exactly 2 cycles is checked on the first sample.
2. Saturation: with offset=+16 learned, apply adc_data=12'h000 -> out_data=-2048 (clamped from -2064). ovr_flag=1 and ovr_count increments per sample. dc_remove_en=0 -> out_data=-2048 without clamping.
3. Gapped strobe: adc_valid high 1 cycle in 4, DC code 12'h7F0 (-16) -> out_valid is spaced 4 cycles at +2 latency. dc_valid rises after the 16th valid (cycle ~62). dbg_dc_offset=-16, giving floor behaviour for a negative mean.
4. Freeze: in TRACK with offset=16, assert offset_freeze, change input to 12'h820 for 40 samples -> dbg_dc_offset stays 16 and out_data=16. Release -> offset becomes 32 after 16 further samples.
5. Overrange clear and collision: adc_ovr pulsed 3 times -> ovr_count=3. ovr_clear alone -> 0/0. ovr_clear coincident with an event -> flag=1, count=1. Force count near max (CNT_W=4) -> holds at 15.
6. Reset mid-window: after 10 of 16 samples at 12'h810, assert rst for 1 cycle -> all outputs 0, FSM=WARMUP. dc_valid rises only after 16 new samples; the offset reflects post-reset data only.
